// File: rtl/decoder_scan_seq.sv
// Scan sequencer feeding a 2-to-4 decoder: steps {A1,A0} through 00..11 with a
// programmable dwell per code. Codes are separated by a blanking gap with en
// low, so the address only moves while the decoder is disabled.
module decoder_scan_seq #(
    parameter int unsigned DWELL_W = 8,
    parameter int unsigned BLANK   = 1   // legal range 1..15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic               A1,
    output logic               A0,
    output logic               en,
    output logic               busy,
    output logic               sweep_done
);

    localparam int unsigned BLANK_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         code_q, code_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [DWELL_W-1:0] dwell_eff;
    logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
    logic               mode_q, mode_d;
    logic               run_q;
    logic               start;
    logic               sweep_done_d;

    // A dwell of zero behaves like one cycle
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    // Single-sweep mode starts only on a rising edge of run
    assign start = mode ? (run & ~run_q) : run;

    // The address register is itself the decoder select
    assign A1 = code_q[1];
    assign A0 = code_q[0];

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            code_q      <= 2'b00;
            dwell_cnt_q <= '0;
            blank_cnt_q <= '0;
            mode_q      <= 1'b0;
            run_q       <= 1'b0;
            en          <= 1'b0;
            busy        <= 1'b0;
            sweep_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            dwell_cnt_q <= dwell_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            mode_q      <= mode_d;
            run_q       <= run;
            en          <= (state_d == ACTIVE);
            busy        <= (state_d != IDLE);
            sweep_done  <= sweep_done_d;
        end
    end

    // Next-state and next-value logic
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        dwell_cnt_d  = dwell_cnt_q;
        blank_cnt_d  = blank_cnt_q;
        mode_d       = mode_q;
        sweep_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                code_d = 2'b00;
                if (start) begin
                    state_d     = ACTIVE;
                    mode_d      = mode;
                    dwell_cnt_d = dwell_eff;
                end
            end

            ACTIVE: begin
                if (dwell_cnt_q > DWELL_W'(1)) begin
                    dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                end else if (!run) begin
                    // Stop request wins over sweep completion
                    state_d     = IDLE;
                    code_d      = 2'b00;
                    dwell_cnt_d = '0;
                end else if ((code_q == 2'b11) && mode_q) begin
                    state_d      = IDLE;
                    code_d       = 2'b00;
                    dwell_cnt_d  = '0;
                    sweep_done_d = 1'b1;
                end else begin
                    state_d      = GAP;
                    code_d       = code_q + 2'd1;
                    blank_cnt_d  = BLANK_W'(BLANK);
                    sweep_done_d = (code_q == 2'b11);
                end
            end

            GAP: begin
                // run is deliberately ignored here; a stop lands after the next dwell
                if (blank_cnt_q > BLANK_W'(1)) begin
                    blank_cnt_d = blank_cnt_q - BLANK_W'(1);
                end else begin
                    state_d     = ACTIVE;
                    blank_cnt_d = '0;
                    dwell_cnt_d = dwell_eff;
                end
            end

            default: begin
                state_d = IDLE;
                code_d  = 2'b00;
            end
        endcase
    end

endmodule
